sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Sits between the on-chip SDRAM controller and its two requesters: the CPU memory port and the HDMI framebuffer fetch.
- Owns the refresh schedule. It generates the periodic refresh itself, so refresh is not a free-running pulse that can collide with CPU traffic.
- Serialises all SDRAM commands. Priority is refresh > video > CPU, with a starvation guard for the CPU.

Parameters:
- REFRESH_CYCLES, 720, I_clk cycles between refresh requests (15 us at 48 MHz).
- MAX_VID_RUN, 4, maximum consecutive video grants while the CPU is waiting.
- ADDR_W, 23, SDRAM word address width.

Ports:
- I_clk  in  1  controller clock, same clock as the sdram block.
- I_rst_n  in  1  asynchronous active-low reset.
- I_cpu_req  in  1  CPU request; held high until O_cpu_grant.
- I_cpu_we  in  4  byte write enables; 0 means read.
- I_cpu_address  in  ADDR_W  CPU word address.
- I_cpu_data  in  32  CPU write data.
- O_cpu_grant  out  1  1-cycle pulse: CPU command issued.
- O_cpu_ready  out  1  1-cycle pulse: CPU access complete; read data valid on O_cpu_data.
- O_cpu_data  out  32  CPU read data.
- I_vid_req  in  1  video read request; held until O_vid_grant.
- I_vid_address  in  ADDR_W  video word address.
- O_vid_grant  out  1  1-cycle pulse: video read issued.
- O_vid_ready  out  1  1-cycle pulse: O_vid_data valid.
- O_vid_data  out  32  video read data.
- O_cmd_read  out  1  to sdram I_cmd_read.
- O_cmd_write  out  1  to sdram I_cmd_write.
- O_cmd_refresh  out  1  to sdram I_cmd_refresh.
- O_address  out  ADDR_W  to sdram I_address.
- O_data_in  out  32  to sdram I_data_in.
- I_data_out  in  32  from sdram O_data_out.
- I_data_ready  in  1  from sdram O_data_ready.
- I_busy  in  1  from sdram O_busy.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, the refresh timer and pending count are 0, and the video run counter is 0. Reset asserted mid-access aborts immediately with no ready pulse. Requesters must re-request after reset.
- Refresh timer:
  - Counts 0..REFRESH_CYCLES-1 and wraps.
  - At each wrap, the 2-bit refresh_pending counter increments, saturating at 3.
  - Pending decrements when a refresh is issued.
  - A simultaneous wrap and issue leaves pending unchanged.
- FSM states:
  - IDLE: may issue one command when I_busy=0. Selection order:
    1. pending!=0 → refresh.
    2. I_vid_req and (run<MAX_VID_RUN or !I_cpu_req) → video read.
    3. I_cpu_req → CPU, write if I_cpu_we!=0, else read.
    4. Otherwise stay in IDLE.
  - On issue: for exactly one cycle, the selected O_cmd_* =1 and the owner's grant =1.
    - O_address and O_data_in are registered with the command and held until the return to IDLE.
    - Next state is GUARD.
  - GUARD: one cycle; I_busy is ignored, because sdram raises busy the cycle after a command. Next state is ACTIVE.
  - ACTIVE:
    - When I_data_ready=1 and the owner is a read: latch I_data_out into the owner's data register and pulse the owner's ready on the next cycle.
    - When I_busy=0: for a CPU write, pulse O_cpu_ready; for a refresh, no pulse. Then return to IDLE.
    - A read that ends without I_data_ready still returns to IDLE, with no ready pulse (error case; the bench flags it).
- Video run counter:
  - Increments on each video grant while I_cpu_req=1.
  - Clears on a CPU grant or whenever I_cpu_req=0.
  - Saturates at MAX_VID_RUN.
- Throughput: there is at most one command in flight, and the minimum spacing between issues is 3 cycles (issue, GUARD, ACTIVE with busy low).
- Invariants:
  - O_cmd_read + O_cmd_write + O_cmd_refresh is never more than 1.
  - Commands are issued only from IDLE.
  - O_cpu_data and O_vid_data hold their last value between ready pulses.
- A request deasserted before its grant is a protocol violation; the arbiter samples the request only in IDLE.

Test Plan:
- Reset release with no requests → first refresh pulse exactly at cycle 720, then every 720 cycles; no grants.
- CPU read at address 0x000123; sdram model returns 0xDEADBEEF → O_cmd_read with O_address=0x000123, one O_cpu_grant, O_cpu_ready with O_cpu_data=0xDEADBEEF.
- CPU write, we=4'b0011, data 0x12345678 → O_cmd_write, O_data_in=0x12345678, O_cpu_ready once when busy falls, no data-ready dependency.
- Video and CPU requesting continuously → grant pattern V,V,V,V,C repeating; the CPU is never starved beyond 4 video grants.
- Sdram busy held for 1500 cycles → pending saturates at 2; after busy falls, two back-to-back refreshes are issued before any pending CPU/video request.
- I_rst_n asserted during ACTIVE of a CPU read → all outputs 0 immediately, no O_cpu_ready; after release, the timer restarts and the first refresh comes at cycle 720.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Serialises refresh, video and CPU commands onto a single SDRAM controller.
// Owns the refresh schedule; priority refresh > video > CPU with a CPU starvation guard.
module sdram_arbiter #(
   parameter int REFRESH_CYCLES = 720,
   parameter int MAX_VID_RUN    = 4,
   parameter int ADDR_W         = 23
) (
   input  logic              I_clk,
   input  logic              I_rst_n,
   input  logic              I_cpu_req,
   input  logic [3:0]        I_cpu_we,
   input  logic [ADDR_W-1:0] I_cpu_address,
   input  logic [31:0]       I_cpu_data,
   output logic              O_cpu_grant,
   output logic              O_cpu_ready,
   output logic [31:0]       O_cpu_data,
   input  logic              I_vid_req,
   input  logic [ADDR_W-1:0] I_vid_address,
   output logic              O_vid_grant,
   output logic              O_vid_ready,
   output logic [31:0]       O_vid_data,
   output logic              O_cmd_read,
   output logic              O_cmd_write,
   output logic              O_cmd_refresh,
   output logic [ADDR_W-1:0] O_address,
   output logic [31:0]       O_data_in,
   input  logic [31:0]       I_data_out,
   input  logic              I_data_ready,
   input  logic              I_busy,
   output logic [1:0]        O_dbg_state
);

   localparam int TMR_W = $clog2(REFRESH_CYCLES);
   localparam int RUN_W = $clog2(MAX_VID_RUN + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_ACTIVE} state_t;
   typedef enum logic [1:0] {OWN_REF, OWN_VID, OWN_CPU_RD, OWN_CPU_WR} owner_t;

   state_t              state_q;
   owner_t              owner_q;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [1:0]          pending_q, pending_d;
   logic [RUN_W-1:0]    run_q, run_d;
   logic                cmd_read_q, cmd_write_q, cmd_refresh_q;
   logic                cpu_grant_q, vid_grant_q, cpu_ready_q, vid_ready_q;
   logic [ADDR_W-1:0]   address_q;
   logic [31:0]         data_in_q, cpu_data_q, vid_data_q;

   logic wrap, can_issue, sel_ref, sel_vid, issue_ref, issue_vid, issue_cpu;

   // Handshake: a requester holds req (and its address/data) stable until it
   // sees its 1-cycle grant; req is sampled only in IDLE, and the matching
   // ready pulse later marks completion (never for a refresh).
   always_comb begin
      wrap      = (timer_q == TMR_W'(REFRESH_CYCLES - 1));
      timer_d   = wrap ? '0 : timer_q + 1'b1;
      can_issue = (state_q == ST_IDLE) && !I_busy;
      sel_ref   = (pending_q != 2'd0);
      sel_vid   = I_vid_req && ((run_q < RUN_W'(MAX_VID_RUN)) || !I_cpu_req);
      issue_ref = can_issue && sel_ref;
      issue_vid = can_issue && !sel_ref && sel_vid;
      issue_cpu = can_issue && !sel_ref && !sel_vid && I_cpu_req;

      pending_d = pending_q;
      if (wrap && !issue_ref && pending_q != 2'd3)
         pending_d = pending_q + 2'd1;
      else if (!wrap && issue_ref)
         pending_d = pending_q - 2'd1;

      run_d = run_q;
      if (issue_cpu || !I_cpu_req)
         run_d = '0;
      else if (issue_vid && run_q < RUN_W'(MAX_VID_RUN))
         run_d = run_q + 1'b1;
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q       <= ST_IDLE;
         owner_q       <= OWN_REF;
         timer_q       <= '0;
         pending_q     <= '0;
         run_q         <= '0;
         cmd_read_q    <= 1'b0;
         cmd_write_q   <= 1'b0;
         cmd_refresh_q <= 1'b0;
         cpu_grant_q   <= 1'b0;
         vid_grant_q   <= 1'b0;
         cpu_ready_q   <= 1'b0;
         vid_ready_q   <= 1'b0;
         address_q     <= '0;
         data_in_q     <= '0;
         cpu_data_q    <= '0;
         vid_data_q    <= '0;
      end else begin
         timer_q       <= timer_d;
         pending_q     <= pending_d;
         run_q         <= run_d;
         cmd_read_q    <= 1'b0;
         cmd_write_q   <= 1'b0;
         cmd_refresh_q <= 1'b0;
         cpu_grant_q   <= 1'b0;
         vid_grant_q   <= 1'b0;
         cpu_ready_q   <= 1'b0;
         vid_ready_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (issue_ref) begin
                  cmd_refresh_q <= 1'b1;
                  owner_q       <= OWN_REF;
                  state_q       <= ST_GUARD;
               end else if (issue_vid) begin
                  cmd_read_q  <= 1'b1;
                  vid_grant_q <= 1'b1;
                  owner_q     <= OWN_VID;
                  address_q   <= I_vid_address;
                  state_q     <= ST_GUARD;
               end else if (issue_cpu) begin
                  cpu_grant_q <= 1'b1;
                  address_q   <= I_cpu_address;
                  data_in_q   <= I_cpu_data;
                  state_q     <= ST_GUARD;
                  if (|I_cpu_we) begin
                     cmd_write_q <= 1'b1;
                     owner_q     <= OWN_CPU_WR;
                  end else begin
                     cmd_read_q <= 1'b1;
                     owner_q    <= OWN_CPU_RD;
                  end
               end
            end
            // The controller only raises busy the cycle after a command.
            ST_GUARD: state_q <= ST_ACTIVE;
            ST_ACTIVE: begin
               if (I_data_ready) begin
                  if (owner_q == OWN_VID) begin
                     vid_data_q  <= I_data_out;
                     vid_ready_q <= 1'b1;
                  end else if (owner_q == OWN_CPU_RD) begin
                     cpu_data_q  <= I_data_out;
                     cpu_ready_q <= 1'b1;
                  end
               end
               if (!I_busy) begin
                  if (owner_q == OWN_CPU_WR)
                     cpu_ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign O_cmd_read    = cmd_read_q;
   assign O_cmd_write   = cmd_write_q;
   assign O_cmd_refresh = cmd_refresh_q;
   assign O_cpu_grant   = cpu_grant_q;
   assign O_vid_grant   = vid_grant_q;
   assign O_cpu_ready   = cpu_ready_q;
   assign O_vid_ready   = vid_ready_q;
   assign O_cpu_data    = cpu_data_q;
   assign O_vid_data    = vid_data_q;
   assign O_address     = address_q;
   assign O_data_in     = data_in_q;
   assign O_dbg_state   = state_q;

endmodule
